add_multicycle: RTL and testbench
=================================

ADD_MULTICYCLE -- requirements
Module: add_multicycle

Interface
REQ-001 Parameter WIDTH, default 64, operand and result width in bits.
REQ-002 Parameter CHUNK, default 16, bits added per cycle; WIDTH SHALL be a positive multiple of CHUNK, and NCHUNK = WIDTH/CHUNK.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 in_valid  input  1  abus, bbus and cin are valid.
REQ-006 in_ready  output  1  block can accept operands.
REQ-007 abus  input  WIDTH  first addend, unsigned.
REQ-008 bbus  input  WIDTH  second addend, unsigned.
REQ-009 cin  input  1  carry-in added at bit 0.
REQ-010 out  output  WIDTH  sum, (abus + bbus + cin) mod 2^WIDTH.
REQ-011 cout  output  1  carry out of bit WIDTH-1.
REQ-012 out_valid  output  1  out and cout hold a completed result.
REQ-013 out_ready  input  1  consumer accepts the result.

Function
REQ-014 The FSM SHALL have three states: IDLE, ADD and DONE.
REQ-015 in_ready SHALL be 1 exactly in IDLE; out_valid SHALL be 1 exactly in DONE; both are registered-state decodes with no combinational path from inputs.
REQ-016 In IDLE, when in_valid=1 at a rising edge, the block SHALL capture abus, bbus and cin, set the chunk index to 0, load the carry register with cin, and enter ADD.
REQ-017 In ADD, on each edge the block SHALL add chunk[idx] of the captured operands plus the carry register, write the CHUNK-bit sum into out[idx*CHUNK +: CHUNK], update the carry register with the chunk carry, and increment idx.
REQ-018 On the edge that processes idx = NCHUNK-1, the block SHALL load cout from the final carry and enter DONE.
REQ-019 out_valid SHALL rise exactly NCHUNK cycles after the capture edge; for the defaults this is 4 cycles.
REQ-020 In DONE, out and cout SHALL hold stable until out_ready=1 at an edge; the block SHALL then return to IDLE.
REQ-021 A result SHALL NOT be accepted and a new operand SHALL NOT be captured on the same edge; after a result is accepted, in_ready rises one cycle later.
REQ-022 Changes to abus, bbus, cin and in_valid outside IDLE SHALL be ignored; the captured operands are the only inputs to the computation.
REQ-023 out_ready outside DONE SHALL have no effect.
REQ-024 When NCHUNK=1, ADD SHALL last one cycle and REQ-019 SHALL still hold, giving a latency of 1.
REQ-025 Wrap-around: a result of 2^WIDTH or more SHALL be reported mod 2^WIDTH with cout=1; there is no other overflow flag.
REQ-026 The out bits not yet written in ADD are unspecified until DONE; consumers SHALL sample them only while out_valid=1.

Reset
REQ-027 When rst_n=0, the block SHALL immediately, without waiting for clk, set the state to IDLE, idx to 0, the carry register to 0, and out, cout and out_valid to 0; in_ready SHALL be 1.
REQ-028 A reset asserted during ADD or DONE SHALL abort the operation and discard the result; after release, the first in_valid SHALL start a fresh computation.
REQ-029 The block SHALL capture nothing on the first edge at which rst_n is already 1 only if in_valid=0; otherwise normal IDLE capture SHALL apply.

Verification
REQ-030 Basic: WIDTH=64, CHUNK=16, a=0x0000_0000_0000_0001, b=0x0000_0000_0000_0002, cin=0 -> out=0x3, cout=0, out_valid high 4 cycles after capture.
REQ-031 Carry ripple across chunks: a=0xFFFF_FFFF_FFFF_FFFF, b=0, cin=1 -> out=0, cout=1.
REQ-032 Backpressure: hold out_ready=0 for 10 cycles in DONE while abus and bbus toggle -> out, cout and out_valid stay stable and in_ready stays 0; pulse out_ready=1 -> IDLE next cycle.
REQ-033 Mid-operation reset: capture a=0x1234, b=0x1; assert rst_n=0 for 1 cycle during ADD idx=2 -> all outputs 0 and in_ready=1 asynchronously; a new operation a=5, b=7 -> out=12.
REQ-034 Back-to-back: 100 random operand triples with in_valid held high and random out_ready -> each result equals (a+b+cin) mod 2^64 with the correct cout, in order, with none dropped or duplicated.
REQ-035 Parameter sweep: (WIDTH, CHUNK) = (8,8), (32,8) and (1024,64) with random operands -> results match the reference model and latency equals NCHUNK.

Source files
------------

// File: rtl/add_multicycle.sv
// Multi-cycle adder: sums two WIDTH-bit operands CHUNK bits per cycle.
// Valid/ready handshake on both sides; result held until accepted.
module add_multicycle #(
   parameter int WIDTH = 64,
   parameter int CHUNK = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] abus,
   input  logic [WIDTH-1:0] bbus,
   input  logic             cin,
   output logic [WIDTH-1:0] out,
   output logic             cout,
   output logic             out_valid,
   input  logic             out_ready
);

   localparam int NCHUNK = WIDTH / CHUNK;
   localparam int IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
   localparam logic [IW-1:0] LAST = IW'(NCHUNK - 1);

   typedef enum logic [1:0] {
      IDLE,
      ADD,
      DONE
   } state_t;

   state_t state;
   state_t state_n;

   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic [IW-1:0]    idx;
   logic             carry;

   logic [CHUNK-1:0] a_c;
   logic [CHUNK-1:0] b_c;
   logic [CHUNK:0]   sum;
   logic             last;

   // Select the current chunk of the captured operands and add it.
   always_comb begin
      a_c  = a_q[idx*CHUNK +: CHUNK];
      b_c  = b_q[idx*CHUNK +: CHUNK];
      sum  = {1'b0, a_c} + {1'b0, b_c} + {{CHUNK{1'b0}}, carry};
      last = (idx == LAST);
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_n;
      end
   end

   // Next-state logic; handshake outputs are pure state decodes.
   always_comb begin
      state_n   = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      unique case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               state_n = ADD;
            end
         end
         ADD: begin
            if (last) begin
               state_n = DONE;
            end
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) begin
               state_n = IDLE;
            end
         end
         default: begin
            state_n = IDLE;
         end
      endcase
   end

   // Operand capture, chunk-serial accumulation and result registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_q   <= '0;
         b_q   <= '0;
         idx   <= '0;
         carry <= 1'b0;
         out   <= '0;
         cout  <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (in_valid) begin
                  a_q   <= abus;
                  b_q   <= bbus;
                  idx   <= '0;
                  carry <= cin;
               end
            end
            ADD: begin
               out[idx*CHUNK +: CHUNK] <= sum[CHUNK-1:0];
               carry <= sum[CHUNK];
               if (last) begin
                  idx  <= '0;
                  cout <= sum[CHUNK];
               end else begin
                  idx <= idx + 1'b1;
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_add_multicycle.sv
// Self-checking bench for add_multicycle.
// Default 64/16 instance plus 8/8, 32/8 and 1024/64 sweep instances.
module tb_add_multicycle;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [63:0] abus;
   logic [63:0] bbus;
   logic        cin;
   logic [63:0] out;
   logic        cout;
   logic        out_valid;
   logic        out_ready;

   logic          s_valid;
   logic          s_ready;
   logic          s_cin;
   logic [7:0]    a8, b8, o8;
   logic [31:0]   a32, b32, o32;
   logic [1023:0] a1k, b1k, o1k;
   logic          c8, c32, c1k;
   logic          ov8, ov32, ov1k;
   logic          ir8, ir32, ir1k;

   int n_chk;
   int n_fail;

   add_multicycle dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .abus(abus), .bbus(bbus), .cin(cin),
      .out(out), .cout(cout),
      .out_valid(out_valid), .out_ready(out_ready)
   );

   add_multicycle #(.WIDTH(8), .CHUNK(8)) u8 (
      .clk(clk), .rst_n(rst_n),
      .in_valid(s_valid), .in_ready(ir8),
      .abus(a8), .bbus(b8), .cin(s_cin),
      .out(o8), .cout(c8),
      .out_valid(ov8), .out_ready(s_ready)
   );

   add_multicycle #(.WIDTH(32), .CHUNK(8)) u32 (
      .clk(clk), .rst_n(rst_n),
      .in_valid(s_valid), .in_ready(ir32),
      .abus(a32), .bbus(b32), .cin(s_cin),
      .out(o32), .cout(c32),
      .out_valid(ov32), .out_ready(s_ready)
   );

   add_multicycle #(.WIDTH(1024), .CHUNK(64)) u1k (
      .clk(clk), .rst_n(rst_n),
      .in_valid(s_valid), .in_ready(ir1k),
      .abus(a1k), .bbus(b1k), .cin(s_cin),
      .out(o1k), .cout(c1k),
      .out_valid(ov1k), .out_ready(s_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag,
                        input logic [63:0] got,
                        input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic run_op(input logic [63:0] av,
                         input logic [63:0] bv,
                         input logic        c,
                         input logic [63:0] eo,
                         input logic        ec,
                         input string       tag);
      int lat;
      abus     = av;
      bbus     = bv;
      cin      = c;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat < 20) begin
         tick();
         lat++;
      end
      check({tag, "_lat"}, 64'(lat), 64'd4);
      check({tag, "_out"}, out, eo);
      check({tag, "_cout"}, 64'(cout), 64'(ec));
   endtask

   task automatic accept(input string tag);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check({tag, "_irdy"}, 64'(in_ready), 64'd1);
      check({tag, "_oval"}, 64'(out_valid), 64'd0);
   endtask

   initial begin
      logic [63:0] hold_o;
      logic        hold_c;
      logic [64:0] q[$];
      logic [64:0] e;
      logic [8:0]  e8;
      logic [32:0] e32;
      logic [1024:0] e1k;
      int caps, accs, cyc;
      int l8, l32, l1k;

      n_chk     = 0;
      n_fail    = 0;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      abus      = '0;
      bbus      = '0;
      cin       = 1'b0;
      s_valid   = 1'b0;
      s_ready   = 1'b0;
      s_cin     = 1'b0;
      a8 = '0; b8 = '0; a32 = '0; b32 = '0; a1k = '0; b1k = '0;

      #1;
      check("rst_irdy", 64'(in_ready), 64'd1);
      check("rst_oval", 64'(out_valid), 64'd0);
      check("rst_out", out, 64'd0);
      check("rst_cout", 64'(cout), 64'd0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;

      run_op(64'h1, 64'h2, 1'b0, 64'h3, 1'b0, "basic");
      accept("basic");

      run_op(64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 64'h0, 1'b1, "ripple");
      accept("ripple");

      run_op(64'h0123_4567_89AB_CDEF, 64'h1111_1111_1111_1111, 1'b0,
             64'h1234_5678_9ABC_DF00, 1'b0, "mixed");
      accept("mixed");

      run_op(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0001, 1'b1,
             64'h2, 1'b1, "bp");
      hold_o = 64'h2;
      hold_c = 1'b1;
      for (int i = 0; i < 10; i++) begin
         abus     = {$urandom, $urandom};
         bbus     = {$urandom, $urandom};
         cin      = 1'($urandom);
         in_valid = 1'($urandom);
         tick();
         check("bp_out", out, hold_o);
         check("bp_cout", 64'(cout), 64'(hold_c));
         check("bp_oval", 64'(out_valid), 64'd1);
         check("bp_irdy", 64'(in_ready), 64'd0);
      end
      in_valid = 1'b1;
      abus     = 64'd5;
      bbus     = 64'd6;
      cin      = 1'b0;
      accept("bp");
      run_op(64'd5, 64'd6, 1'b0, 64'd11, 1'b0, "bp_next");
      accept("bp_next");

      abus     = 64'h1234;
      bbus     = 64'h1;
      cin      = 1'b0;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      tick();
      tick();
      rst_n = 1'b0;
      #1;
      check("mrst_irdy", 64'(in_ready), 64'd1);
      check("mrst_oval", 64'(out_valid), 64'd0);
      check("mrst_out", out, 64'd0);
      check("mrst_cout", 64'(cout), 64'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      run_op(64'd5, 64'd7, 1'b0, 64'd12, 1'b0, "mrst_new");
      accept("mrst_new");

      caps = 0;
      accs = 0;
      cyc  = 0;
      while (accs < 100 && cyc < 3000) begin
         abus      = {$urandom, $urandom};
         bbus      = {$urandom, $urandom};
         cin       = 1'($urandom);
         in_valid  = (caps < 100);
         out_ready = 1'($urandom);
         if (in_ready && in_valid) begin
            q.push_back({1'b0, abus} + {1'b0, bbus} + 65'(cin));
            caps++;
         end
         if (out_valid && out_ready) begin
            if (q.size() == 0) begin
               check("b2b_extra", 64'd1, 64'd0);
            end else begin
               e = q.pop_front();
               check("b2b_out", out, e[63:0]);
               check("b2b_cout", 64'(cout), 64'(e[64]));
            end
            accs++;
         end
         tick();
         cyc++;
      end
      in_valid  = 1'b0;
      out_ready = 1'b0;
      check("b2b_count", 64'(accs), 64'd100);
      check("b2b_left", 64'(q.size()), 64'd0);

      for (int v = 0; v < 3; v++) begin
         if (v == 0) begin
            a8 = '1; b8 = '0; a32 = '1; b32 = '0;
            a1k = '1; b1k = '0; s_cin = 1'b1;
         end else begin
            a8  = 8'($urandom);
            b8  = 8'($urandom);
            a32 = $urandom;
            b32 = $urandom;
            for (int w = 0; w < 32; w++) begin
               a1k[w*32 +: 32] = $urandom;
               b1k[w*32 +: 32] = $urandom;
            end
            s_cin = 1'($urandom);
         end
         e8  = {1'b0, a8} + {1'b0, b8} + 9'(s_cin);
         e32 = {1'b0, a32} + {1'b0, b32} + 33'(s_cin);
         e1k = {1'b0, a1k} + {1'b0, b1k} + 1025'(s_cin);
         s_valid = 1'b1;
         tick();
         s_valid = 1'b0;
         l8 = -1; l32 = -1; l1k = -1;
         for (int c = 1; c <= 20; c++) begin
            tick();
            if (ov8 && l8 < 0) l8 = c;
            if (ov32 && l32 < 0) l32 = c;
            if (ov1k && l1k < 0) l1k = c;
         end
         check("sw8_lat", 64'(l8), 64'd1);
         check("sw32_lat", 64'(l32), 64'd4);
         check("sw1k_lat", 64'(l1k), 64'd16);
         check("sw8_out", 64'(o8), 64'(e8[7:0]));
         check("sw8_cout", 64'(c8), 64'(e8[8]));
         check("sw32_out", 64'(o32), 64'(e32[31:0]));
         check("sw32_cout", 64'(c32), 64'(e32[32]));
         for (int w = 0; w < 16; w++) begin
            check($sformatf("sw1k_out%0d", w), o1k[w*64 +: 64], e1k[w*64 +: 64]);
         end
         check("sw1k_cout", 64'(c1k), 64'(e1k[1024]));
         s_ready = 1'b1;
         tick();
         s_ready = 1'b0;
         check("sw_irdy", 64'({ir8, ir32, ir1k}), 64'd7);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
